// File: rtl/aes_uart_host_pkg.sv
// Shared definitions for the AES serial-link host: controller state encoding
// and UART framing constants.
package aes_uart_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } host_state_e;

    localparam int BLOCK_BYTES = 16;
    localparam int FRAME_BITS  = 10;

endpackage

// File: rtl/aes_uart_host_if.sv
// Local-logic side of the AES serial-link host: block request and result.
interface aes_uart_host_if;
    logic         start_in;
    logic [127:0] block_in;
    logic         busy_out;
    logic         done_out;
    logic [127:0] block_out;
    logic         timeout_out;

    modport master (output start_in, block_in,
                    input  busy_out, done_out, block_out, timeout_out);
    modport slave  (input  start_in, block_in,
                    output busy_out, done_out, block_out, timeout_out);
endinterface

// File: rtl/aes_host_uart_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, falling-edge start detect confirmed at
// mid-bit, centre sampling; pulses byte_valid or frame_err on the stop bit.
module aes_host_uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial_in,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     st_q, st_d;
    logic [2:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, byte_q, byte_d;
    logic          valid_q, valid_d, err_q, err_d;
    logic          rx_s, rx_prev, at_mid, at_end;

    // sync_q[1] is the synchronized line; sync_q[2] is its previous value.
    assign rx_s    = sync_q[1];
    assign rx_prev = sync_q[2];
    assign at_mid  = (cnt_q == CW'(CLKS_PER_BIT/2 - 1));
    assign at_end  = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        sync_d  = {sync_q[1:0], rx_serial_in};
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev && !rx_s) st_d = RX_START;
            end
            RX_START: if (at_mid) begin
                cnt_d = '0;
                bit_d = '0;
                st_d  = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (at_end) begin
                cnt_d   = '0;
                shift_d = {rx_s, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) st_d = RX_STOP;
            end
            RX_STOP: if (at_end) begin
                st_d = RX_IDLE;
                if (rx_s) begin
                    valid_d = 1'b1;
                    byte_d  = shift_q;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= RX_IDLE;
            sync_q  <= '1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            st_q    <= st_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = err_q;
endmodule

// File: rtl/aes_uart_host.sv
// Host side of the AES serial link: sends a 128-bit block as 16 UART bytes and
// gathers the 16-byte reply. Optional reply watchdog: AES_HOST_TIMEOUT_EN.
module aes_uart_host #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 2000000
) (
    input  logic            clk,
    input  logic            rst,
    aes_uart_host_if.slave  host,
    output logic            tx_serial_out,
    input  logic            rx_serial_in
);
    import aes_uart_host_pkg::*;

    localparam int CW = $clog2(CLKS_PER_BIT);

    host_state_e   state_q, state_d;
    logic          tx_serial_q, tx_serial_d, busy_q, busy_d, done_q, done_d;
    logic          timeout_q, timeout_d;
    logic [127:0]  block_out_q, block_out_d, blk_q, blk_d, result_q, result_d;
    logic [8:0]    tx_frame_q, tx_frame_d;
    logic [CW-1:0] tx_clk_q, tx_clk_d;
    logic [3:0]    tx_bit_q, tx_bit_d, tx_byte_q, tx_byte_d;
    logic [4:0]    rx_cnt_q, rx_cnt_d;
    logic [7:0]    rx_byte;
    logic          rx_valid, rx_ferr, rx_take;
`ifdef AES_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

    aes_host_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_serial_in (rx_serial_in),
        .byte_out     (rx_byte),
        .byte_valid   (rx_valid),
        .frame_err    (rx_ferr)
    );

    // Replies may start while we are still sending, so SEND accepts too.
    assign rx_take = rx_valid && !rx_ferr && (state_q == SEND || state_q == RECV)
                     && (rx_cnt_q != 5'(BLOCK_BYTES));

    always_comb begin
        state_d     = state_q;
        tx_serial_d = tx_serial_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        block_out_d = block_out_q;
        blk_d       = blk_q;
        result_d    = result_q;
        tx_frame_d  = tx_frame_q;
        tx_clk_d    = tx_clk_q;
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        rx_cnt_d    = rx_cnt_q;
`ifdef AES_HOST_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
`endif
        if (rx_take) begin
            result_d = {result_q[119:0], rx_byte};
            rx_cnt_d = rx_cnt_q + 1'b1;
        end
        case (state_q)
            IDLE: if (host.start_in) begin
                state_d     = SEND;
                busy_d      = 1'b1;
                blk_d       = {host.block_in[119:0], 8'h00};
                tx_frame_d  = {1'b1, host.block_in[127:120]};
                tx_serial_d = 1'b0;
                tx_clk_d    = '0;
                tx_bit_d    = '0;
                tx_byte_d   = '0;
                rx_cnt_d    = '0;
            end
            SEND: begin
`ifdef AES_HOST_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                if (tx_clk_q == CW'(CLKS_PER_BIT - 1)) begin
                    tx_clk_d = '0;
                    if (tx_bit_q == 4'(FRAME_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (tx_byte_q == 4'(BLOCK_BYTES - 1)) begin
                            state_d     = RECV;
                            tx_serial_d = 1'b1;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap.
                            tx_byte_d   = tx_byte_q + 1'b1;
                            tx_frame_d  = {1'b1, blk_q[127:120]};
                            blk_d       = {blk_q[119:0], 8'h00};
                            tx_serial_d = 1'b0;
                        end
                    end else begin
                        tx_bit_d    = tx_bit_q + 1'b1;
                        tx_serial_d = tx_frame_q[0];
                        tx_frame_d  = {1'b1, tx_frame_q[8:1]};
                    end
                end else begin
                    tx_clk_d = tx_clk_q + 1'b1;
                end
            end
            RECV: begin
                if (rx_cnt_q == 5'(BLOCK_BYTES)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    block_out_d = result_q;
                end
`ifdef AES_HOST_TIMEOUT_EN
                else if (rx_take) to_cnt_d = '0;
                else if (to_cnt_q == TW'(TIMEOUT_CLKS - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end else to_cnt_d = to_cnt_q + 1'b1;
`endif
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_serial_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            block_out_q <= '0;
            blk_q       <= '0;
            result_q    <= '0;
            tx_frame_q  <= '1;
            tx_clk_q    <= '0;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            rx_cnt_q    <= '0;
`ifdef AES_HOST_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tx_serial_q <= tx_serial_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            block_out_q <= block_out_d;
            blk_q       <= blk_d;
            result_q    <= result_d;
            tx_frame_q  <= tx_frame_d;
            tx_clk_q    <= tx_clk_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            rx_cnt_q    <= rx_cnt_d;
`ifdef AES_HOST_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    assign tx_serial_out    = tx_serial_q;
    assign host.busy_out    = busy_q;
    assign host.done_out    = done_q;
    assign host.block_out   = block_out_q;
    assign host.timeout_out = timeout_q;
endmodule

// File: tb/tb_aes_uart_host.sv
// Directed bench for aes_uart_host: loopback, tx line decode, ignored restart,
// framing-error reply, reply timeout (per build), and mid-send reset.
module tb_aes_uart_host;
    localparam int CPB = 4;
    localparam int TO  = 100;
    localparam logic [127:0] B1 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] B2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] B3 = 128'hDEADBEEFCAFEF00D0BADC0DE12345678;
    localparam logic [127:0] B4 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] BC = {{15{8'hFF}}, 8'hA5};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx, rxl;
    logic loopback  = 1'b1;
    logic resp_line = 1'b1;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;
    assign rxl = loopback ? tx : resp_line;

    aes_uart_host_if hif ();

    aes_uart_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .host          (hif.slave),
        .tx_serial_out (tx),
        .rx_serial_in  (rxl)
    );

    // tx line monitor: decodes frames and flags gaps or bad stop bits.
    int cyc = 0;
    int clr_req = 0, clr_ack = 0;
    int m_start = 0, m_frames = 0, m_first = 0, m_end = 0, m_gaps = 0, off;
    logic m_in = 1'b0, m_prev = 1'b1, done_seen = 1'b0, to_seen = 1'b0;
    logic [7:0] m_sh = '0;
    logic [7:0] m_bytes [0:31];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_prev <= tx;
        if (clr_req != clr_ack) begin
            clr_ack   <= clr_req;
            m_frames  <= 0;
            m_gaps    <= 0;
            m_in      <= 1'b0;
            done_seen <= 1'b0;
            to_seen   <= 1'b0;
        end else if (rst) begin
            m_in <= 1'b0;
        end else begin
            if (hif.done_out)    done_seen <= 1'b1;
            if (hif.timeout_out) to_seen   <= 1'b1;
            if (!m_in) begin
                if (m_prev && !tx) begin
                    m_in    <= 1'b1;
                    m_start <= cyc;
                    if (m_frames == 0) m_first <= cyc;
                    else if (cyc != m_end) m_gaps <= m_gaps + 1;
                end
            end else begin
                off = cyc - m_start;
                if (off % CPB == CPB/2 && off/CPB >= 1 && off/CPB <= 8)
                    m_sh <= {tx, m_sh[7:1]};
                if (off == 9*CPB + CPB/2) begin
                    m_in <= 1'b0;
                    if (m_frames < 32) m_bytes[m_frames[4:0]] <= m_sh;
                    m_frames <= m_frames + 1;
                    m_end    <= m_start + 10*CPB;
                    if (!tx) m_gaps <= m_gaps + 1;
                end
            end
        end
    end

    task automatic chk1(input string t, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", t, o, e);
        end
    endtask

    task automatic chk8(input string t, input logic [7:0] o, input logic [7:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic chkv(input string t, input logic [127:0] o, input logic [127:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic chki(input string t, input int o, input int e);
        total++;
        assert (o == e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", t, o, e);
        end
    endtask

    task automatic start_blk(input logic [127:0] b);
        @(negedge clk);
        hif.block_in = b;
        hif.start_in = 1'b1;
        @(negedge clk);
        hif.start_in = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < maxc && !ok) begin
            @(negedge clk);
            n++;
            if (hif.done_out) ok = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        resp_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            resp_line = b[i];
            repeat (CPB) @(negedge clk);
        end
        resp_line = stop_ok;
        repeat (CPB) @(negedge clk);
        resp_line = 1'b1;
        repeat (2*CPB) @(negedge clk);
    endtask

    int n;
    bit ok;

    initial begin
        hif.start_in = 1'b0;
        hif.block_in = '0;
        repeat (3) @(negedge clk);
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_busy", hif.busy_out, 1'b0);
        chk1("rst_done", hif.done_out, 1'b0);
        chk1("rst_timeout", hif.timeout_out, 1'b0);
        chkv("rst_block_out", hif.block_out, '0);
        rst = 1'b0;
        clr_req++;
        repeat (2) @(negedge clk);

        // Loopback of B1 with tx line decode.
        @(negedge clk);
        hif.block_in = B1;
        hif.start_in = 1'b1;
        chk1("tx_idle_before_accept", tx, 1'b1);
        @(negedge clk);
        hif.start_in = 1'b0;
        chk1("tx_start_bit_after_accept", tx, 1'b0);
        chk1("busy_after_accept", hif.busy_out, 1'b1);
        wait_done(800, n, ok);
        chk1("a_done", ok, 1'b1);
        chk1("a_latency_640_660", (n >= 640 && n <= 660), 1'b1);
        chkv("a_block_out", hif.block_out, B1);
        chk1("a_busy_low_with_done", hif.busy_out, 1'b0);
        @(negedge clk);
        chk1("a_done_one_cycle", hif.done_out, 1'b0);
        chki("a_frames", m_frames, 16);
        chk8("a_first_byte", m_bytes[0], 8'h00);
        chk8("a_last_byte", m_bytes[15], 8'hFF);
        chki("a_span", m_end - m_first, 160*CPB);
        chki("a_gaps", m_gaps, 0);
        chk1("a_no_timeout", to_seen, 1'b0);

        // Second start mid-send must be ignored.
        clr_req++;
        start_blk(B2);
        repeat (98) @(negedge clk);
        hif.block_in = B3;
        hif.start_in = 1'b1;
        @(negedge clk);
        hif.start_in = 1'b0;
        wait_done(800, n, ok);
        chk1("b_done", ok, 1'b1);
        chkv("b_block_out", hif.block_out, B2);
        repeat (2) @(negedge clk);
        chki("b_frames", m_frames, 16);
        chk8("b_first_byte", m_bytes[0], 8'h01);

        // Responder: one framing error among 16, then a good 0xA5.
        loopback = 1'b0;
        clr_req++;
        start_blk(B1);
        for (int k = 0; k < 16; k++) send_byte(8'hFF, (k != 3));
        chk1("c_no_done_before_17th", done_seen, 1'b0);
        send_byte(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk1("c_done_after_17th", done_seen, 1'b1);
        chkv("c_block_out", hif.block_out, BC);

        // Reply stalls after 5 bytes.
        clr_req++;
        start_blk(B2);
        repeat (660) @(negedge clk);
        for (int k = 0; k < 5; k++) send_byte(8'h11, 1'b1);
`ifdef AES_HOST_TIMEOUT_EN
        n = 0;
        while (n < 300 && !hif.timeout_out) begin
            @(negedge clk);
            n++;
        end
        chk1("d_timeout_pulse", hif.timeout_out, 1'b1);
        chk1("d_timeout_delay", (n >= 85 && n <= 105), 1'b1);
        chk1("d_busy_low", hif.busy_out, 1'b0);
        @(negedge clk);
        chk1("d_timeout_one_cycle", hif.timeout_out, 1'b0);
        chk1("d_no_done", done_seen, 1'b0);
        chkv("d_block_out_kept", hif.block_out, BC);
`else
        repeat (300) @(negedge clk);
        chk1("d_busy_held", hif.busy_out, 1'b1);
        chk1("d_no_done", done_seen, 1'b0);
        chk1("d_no_timeout", to_seen, 1'b0);
        chkv("d_block_out_kept", hif.block_out, BC);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Reset during byte 7 of a send, then a clean loopback.
        loopback = 1'b1;
        clr_req++;
        start_blk(B1);
        repeat (300) @(negedge clk);
        chk1("e_busy_before_rst", hif.busy_out, 1'b1);
        rst = 1'b1;
        #1;
        chk1("e_rst_tx_high", tx, 1'b1);
        chk1("e_rst_busy_low", hif.busy_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        clr_req++;
        @(negedge clk);
        start_blk(B4);
        wait_done(800, n, ok);
        chk1("e_done", ok, 1'b1);
        chkv("e_block_out", hif.block_out, B4);
        // Start raised in the done cycle is not accepted.
        hif.block_in = B3;
        hif.start_in = 1'b1;
        @(negedge clk);
        hif.start_in = 1'b0;
        chk1("e_start_in_done_ignored", hif.busy_out, 1'b0);
        chk1("e_tx_idle", tx, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
